// File: rtl/comp_bus_arbiter_pkg.sv
// comp_bus_arbiter_pkg: record layout, field selects and helpers shared by the bus arbiter.
package comp_bus_arbiter_pkg;
  localparam int WIDTH = 227;
  localparam int ID_LO = 0;
  localparam int ID_W = 2;
  localparam int TYPE_LO = 2;
  localparam int TYPE_W = 2;
  localparam int F1_LO = 4;
  localparam int F2_LO = 68;
  localparam int F3_LO = 132;
  localparam int FLT_W = 64;
  localparam int EX_LO = 196;
  localparam int EX_W = 31;
  localparam int SUN_BIT = 226;
  typedef enum logic [1:0] {SEL_F1 = 2'd0, SEL_F2 = 2'd1, SEL_F3 = 2'd2, SEL_EXTRA = 2'd3} sel_e;
  typedef enum logic [1:0] {TYPE_AIRFLOW = 2'd0, TYPE_THRUSTERS = 2'd1, TYPE_SOLAR = 2'd2} type_e;
  typedef enum logic [1:0] {IDLE, WRITE, NOTIFY} state_e;
  function automatic int flt_lo(input logic [1:0] sel);
    return sel == SEL_F1 ? F1_LO : sel == SEL_F2 ? F2_LO : F3_LO;
  endfunction
  // extra writes only touch bits whose mask bit is set
  function automatic logic [EX_W-1:0] merge_extra(input logic [EX_W-1:0] old, input logic [63:0] d);
    return (old & ~d[62:32]) | (d[30:0] & d[62:32]);
  endfunction
endpackage

// File: rtl/comp_bus_arbiter_rr_lock_sel.sv
// rr_lock_sel: round-robin winner select with a lock that lets the last winner keep the bus
// for up to four consecutive grants.
module rr_lock_sel #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] valid,
  input  logic [N-1:0] lock,
  output logic [N-1:0] grant,
  output logic [1:0]   idx
);
  logic [1:0] last, cnt, base, c;
  logic hold, held, any;
  always_comb begin
    idx = last;
    c = '0;
    // scan farthest first so the requester nearest last+1 overrides
    for (int k = N; k >= 1; k--) begin
      c = 2'((int'(last) + k) % N);
      if (valid[c]) idx = c;
    end
    any = |valid;
    held = hold && valid[last];
    if (held) idx = last;
    base = held ? cnt : 2'd0;
    grant = '0;
    if (en && any) grant[idx] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= 2'(N - 1);
      hold <= 1'b0;
      cnt <= 2'd0;
    end else if (en) begin
      if (any) last <= idx;
      hold <= any && lock[idx] && base != 2'd3;
      cnt <= (any && lock[idx] && base != 2'd3) ? base + 2'd1 : 2'd0;
    end
endmodule

// File: rtl/comp_bus_arbiter.sv
// comp_bus_arbiter: arbitrates requester writes into component records and notifies a logger
// of each completed update.
module comp_bus_arbiter
  import comp_bus_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int N_COMP = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_lock,
  input  logic [2*N_REQ-1:0] req_id,
  input  logic [2*N_REQ-1:0] req_sel,
  input  logic [64*N_REQ-1:0] req_data,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [1:0]         upd_src,
  output logic [1:0]         upd_id,
  output logic [1:0]         upd_sel,
  output logic [63:0]        upd_data,
  output logic               upd_err,
  input  logic [1:0]         rd_id,
  output logic [WIDTH-1:0]   rd_word,
  output logic               busy
);
  state_e state;
  logic [1:0] win, cap_src, cap_id, cap_sel;
  logic [63:0] cap_data;
  logic [WIDTH-1:0] rec [N_COMP];
  logic [WIDTH-1:0] old, nxt;
  logic [EX_W-1:0] ex_new;
  logic id_ok;
  rr_lock_sel #(.N(N_REQ)) u_sel (
    .clk(CLK),
    .rst_n(RST_N),
    .en(state == IDLE && RST_N),
    .valid(req_valid),
    .lock(req_lock),
    .grant(req_ready),
    .idx(win)
  );
  assign busy = state != IDLE;
  always_comb begin
    old = '0;
    rd_word = '0;
    for (int i = 0; i < N_COMP; i++) begin
      if (cap_id == 2'(i)) old = rec[i];
      if (rd_id == 2'(i)) rd_word = rec[i];
    end
    id_ok = 32'(cap_id) < N_COMP;
    ex_new = merge_extra(old[EX_LO +: EX_W], cap_data);
    nxt = old;
    if (cap_sel == SEL_EXTRA) nxt[EX_LO +: EX_W] = ex_new;
    else nxt[flt_lo(cap_sel) +: FLT_W] = cap_data;
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= IDLE;
      upd_valid <= 1'b0;
      upd_err <= 1'b0;
      upd_src <= '0;
      upd_id <= '0;
      upd_sel <= '0;
      upd_data <= '0;
      cap_src <= '0;
      cap_id <= '0;
      cap_sel <= '0;
      cap_data <= '0;
      for (int i = 0; i < N_COMP; i++) rec[i] <= WIDTH'(i);
    end else begin
      case (state)
        IDLE: if (|req_ready) begin
          cap_src <= win;
          cap_id <= req_id[{win, 1'b0} +: 2];
          cap_sel <= req_sel[{win, 1'b0} +: 2];
          cap_data <= req_data[{win, 6'b0} +: 64];
          state <= WRITE;
        end
        WRITE: begin
          for (int i = 0; i < N_COMP; i++) if (cap_id == 2'(i)) rec[i] <= nxt;
          upd_valid <= 1'b1;
          upd_src <= cap_src;
          upd_id <= cap_id;
          upd_sel <= cap_sel;
          upd_data <= cap_sel == SEL_EXTRA ? 64'(ex_new) : cap_data;
          upd_err <= !id_ok;
          state <= NOTIFY;
        end
        NOTIFY: if (upd_ready) begin
          upd_valid <= 1'b0;
          upd_err <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_comp_bus_arbiter.sv
// tb_comp_bus_arbiter: directed and random stimulus checked against a transaction-level model.
module tb_comp_bus_arbiter;
  localparam int NC = 3;
  logic CLK = 1'b0, RST_N = 1'b0;
  logic [3:0] req_valid, req_ready, req_lock;
  logic [7:0] req_id, req_sel;
  logic [255:0] req_data;
  logic upd_valid, upd_ready, upd_err, busy;
  logic [1:0] upd_src, upd_id, upd_sel, rd_id;
  logic [63:0] upd_data;
  logic [226:0] rd_word;
  int n_chk = 0, n_fail = 0;
  int exp5[5] = '{2, 2, 2, 2, 3};

  always #5 CLK = ~CLK;

  comp_bus_arbiter #(.N_REQ(4), .N_COMP(NC)) dut (
    .CLK(CLK), .RST_N(RST_N), .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
    .req_id(req_id), .req_sel(req_sel), .req_data(req_data), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_src(upd_src), .upd_id(upd_id), .upd_sel(upd_sel),
    .upd_data(upd_data), .upd_err(upd_err), .rd_id(rd_id), .rd_word(rd_word), .busy(busy)
  );

  // model: phase 0 = free, 1 = writing, 2 = notifying
  int m_phase, m_last, m_owner, m_run;
  logic [63:0] m_flt [NC][3];
  logic [30:0] m_ext [NC];
  int t_src, t_id, t_sel;
  logic [63:0] t_data, n_data;
  logic n_err;

  task automatic cmp(input string nm, input logic [226:0] got, input logic [226:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", nm);
  endtask

  function automatic int pick(input logic [3:0] v);
    if (m_owner >= 0 && v[m_owner]) return m_owner;
    for (int k = 1; k <= 4; k++) if (v[(m_last + k) % 4]) return (m_last + k) % 4;
    return -1;
  endfunction

  function automatic logic [226:0] mword(input int i);
    if (i >= NC) return '0;
    return {m_ext[i], m_flt[i][2], m_flt[i][1], m_flt[i][0], 2'b00, 2'(i)};
  endfunction

  task automatic mreset();
    m_phase = 0; m_last = 3; m_owner = -1; m_run = 0;
    for (int i = 0; i < NC; i++) begin
      m_ext[i] = '0;
      for (int j = 0; j < 3; j++) m_flt[i][j] = '0;
    end
  endtask

  task automatic mstep();
    int w;
    logic [30:0] o, ne;
    logic ok;
    if (m_phase == 0) begin
      w = pick(req_valid);
      if (w < 0) begin
        m_owner = -1; m_run = 0;
      end else begin
        m_last = w;
        if (req_lock[w]) begin
          if (w == m_owner) m_run++;
          else begin m_owner = w; m_run = 1; end
          if (m_run == 4) begin m_owner = -1; m_run = 0; end
        end else begin
          m_owner = -1; m_run = 0;
        end
        t_src = w;
        t_id = int'(req_id[2*w +: 2]);
        t_sel = int'(req_sel[2*w +: 2]);
        t_data = req_data[64*w +: 64];
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      ok = t_id < NC;
      if (t_sel == 3) begin
        o = ok ? m_ext[t_id] : 31'd0;
        ne = (o & ~t_data[62:32]) | (t_data[30:0] & t_data[62:32]);
        if (ok) m_ext[t_id] = ne;
        n_data = {33'd0, ne};
      end else begin
        if (ok) m_flt[t_id][t_sel] = t_data;
        n_data = t_data;
      end
      n_err = !ok;
      m_phase = 2;
    end else if (upd_ready) m_phase = 0;
  endtask

  always @(posedge CLK or negedge RST_N)
    if (!RST_N) mreset();
    else mstep();

  always @(negedge CLK) begin
    int w;
    logic [3:0] er;
    #2;
    w = pick(req_valid);
    er = (RST_N && m_phase == 0 && w >= 0) ? 4'(1 << w) : 4'b0;
    cmp("req_ready", 227'(req_ready), 227'(er));
    cmp("busy", 227'(busy), 227'(m_phase != 0));
    cmp("upd_valid", 227'(upd_valid), 227'(m_phase == 2));
    if (m_phase == 2) begin
      cmp("upd_src", 227'(upd_src), 227'(t_src));
      cmp("upd_id", 227'(upd_id), 227'(t_id));
      cmp("upd_sel", 227'(upd_sel), 227'(t_sel));
      cmp("upd_data", 227'(upd_data), 227'(n_data));
      cmp("upd_err", 227'(upd_err), 227'(n_err));
    end
    cmp("rd_word", rd_word, mword(int'(rd_id)));
  end

  task automatic xfer(input int r, input logic lk, input logic [1:0] id, input logic [1:0] sel,
                      input logic [63:0] d, output logic [63:0] ud);
    int n;
    @(negedge CLK);
    req_valid = 4'(1 << r);
    req_lock = 4'({3'b0, lk} << r);
    req_id[2*r +: 2] = id;
    req_sel[2*r +: 2] = sel;
    req_data[64*r +: 64] = d;
    n = 0;
    #3;
    while (!req_ready[r] && n < 20) begin @(negedge CLK); #3; n++; end
    if (n >= 20) tmo("xfer_grant");
    @(negedge CLK);
    req_valid = '0;
    req_lock = '0;
    n = 0;
    #3;
    while (!upd_valid && n < 20) begin @(negedge CLK); #3; n++; end
    if (n >= 20) tmo("xfer_notify");
    ud = upd_data;
  endtask

  initial begin
    logic [63:0] ud, s_data;
    logic [226:0] w;
    int g[$];
    int t1, t2, s1, s2, n;
    mreset();
    req_valid = 4'hF; req_lock = '0; req_id = '0; req_sel = '0; req_data = '0;
    upd_ready = 1'b1; rd_id = 2'd2;
    repeat (2) @(negedge CLK);
    #3;
    cmp("reset_rd_word2", rd_word, 227'd2);
    cmp("reset_ready", 227'(req_ready), 227'd0);
    cmp("reset_busy", 227'(busy), 227'd0);
    cmp("reset_upd_valid", 227'(upd_valid), 227'd0);
    cmp("reset_upd_err", 227'(upd_err), 227'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    req_valid = 4'b0101;
    #3;
    cmp("first_grant_req0", 227'(req_ready), 227'd1);
    t1 = -1; t2 = -1; s1 = -1; s2 = -1;
    for (int c = 1; c < 8; c++) begin
      @(negedge CLK);
      if (c == 4) req_valid = '0;
      #3;
      if (upd_valid) begin
        if (t1 < 0) begin t1 = c; s1 = int'(upd_src); end
        else if (t2 < 0) begin t2 = c; s2 = int'(upd_src); end
      end
    end
    cmp("rr_first_src", 227'(s1), 227'd0);
    cmp("rr_second_src", 227'(s2), 227'd2);
    cmp("rr_latency", 227'(t1), 227'd2);
    cmp("rr_spacing", 227'(t2 - t1), 227'd3);

    rd_id = 2'd0;
    xfer(1, 1'b0, 2'd0, 2'd1, $realtobits(120.0), ud);
    w = rd_word;
    cmp("f2_120_rec", 227'(w[131:68]), 227'(64'h405E000000000000));
    cmp("f2_120_upd", 227'(ud), 227'(64'h405E000000000000));
    xfer(1, 1'b0, 2'd0, 2'd3, 64'h7FFFFFFF_55555555, ud);
    w = rd_word;
    cmp("extra_set_upd", 227'(ud), 227'(64'h55555555));
    cmp("sun_set", 227'(w[226]), 227'd1);
    xfer(1, 1'b0, 2'd0, 2'd3, 64'h40000000_00000000, ud);
    w = rd_word;
    cmp("sun_clr_upd", 227'(ud), 227'(64'h15555555));
    cmp("sun_clr_field", 227'(w[226:196]), 227'(31'h15555555));
    cmp("f2_kept", 227'(w[131:68]), 227'(64'h405E000000000000));

    @(negedge CLK);
    req_valid = 4'hF; req_lock = 4'b0100; req_id = 8'hFF; req_sel = 8'h00;
    req_data = {8{32'hA5A5_0F0F}};
    n = 0;
    #3;
    while (g.size() < 5 && n < 60) begin
      if (req_ready != 0) g.push_back($clog2(req_ready));
      @(negedge CLK);
      n++;
      if (g.size() == 5) begin req_valid = '0; req_lock = '0; end
      #3;
    end
    if (g.size() < 5) tmo("lock_grants");
    else for (int i = 0; i < 5; i++) cmp($sformatf("lock_grant%0d", i), 227'(g[i]), 227'(exp5[i]));

    n = 0;
    while (busy && n < 20) begin @(negedge CLK); #3; n++; end
    @(negedge CLK);
    req_valid = 4'b0001; req_id[1:0] = 2'd3; req_sel[1:0] = 2'd0;
    req_data[63:0] = 64'h0123_4567_89AB_CDEF; upd_ready = 1'b0;
    #3;
    cmp("stall_grant_req0", 227'(req_ready), 227'd1);
    @(negedge CLK);
    req_valid = 4'hF;
    n = 0;
    #3;
    while (!upd_valid && n < 20) begin @(negedge CLK); #3; n++; end
    if (n >= 20) tmo("stall_notify");
    s_data = upd_data;
    cmp("stall_data_lit", 227'(s_data), 227'(64'h0123_4567_89AB_CDEF));
    cmp("stall_err_lit", 227'(upd_err), 227'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      #3;
      cmp("stall_valid", 227'(upd_valid), 227'd1);
      cmp("stall_data", 227'(upd_data), 227'(s_data));
      cmp("stall_ready_low", 227'(req_ready), 227'd0);
    end
    @(negedge CLK);
    req_valid = '0; upd_ready = 1'b1;
    @(negedge CLK);
    rd_id = 2'd0;
    req_valid = 4'b0001; req_id[1:0] = 2'd0; req_sel[1:0] = 2'd0;
    req_data[63:0] = 64'hDEADBEEF_00000000;
    #3;
    cmp("rstmid_grant", 227'(req_ready), 227'd1);
    @(negedge CLK);
    req_valid = '0;
    #1;
    RST_N = 1'b0;
    #2;
    cmp("rstmid_busy", 227'(busy), 227'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    #3;
    cmp("rstmid_record", rd_word, 227'd0);
    repeat (3) begin
      @(negedge CLK);
      #3;
      cmp("rstmid_no_notify", 227'(upd_valid), 227'd0);
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      RST_N = $urandom_range(0, 299) != 0;
      req_valid = 4'($urandom | $urandom);
      req_lock = 4'($urandom | $urandom);
      req_id = 8'($urandom);
      req_sel = 8'($urandom);
      req_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      upd_ready = $urandom_range(0, 3) != 0;
      rd_id = 2'($urandom);
    end
    @(negedge CLK);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
